// File: rtl/tdc_fine_encoder.sv
// Tapped-delay-line TDC fine encoder: re-samples the raw tap vector, converts
// the edge position to a bubble-tolerant fine code and queues timestamps.
//
// Ports:
//   CLK, RST          clock and synchronous active-high reset
//   taps              raw carry-chain tap vector, asynchronous to CLK
//   out_valid/ready   FWFT timestamp queue handshake
//   out_pol           taps[0] value of the sample that produced the entry
//   out_coarse        coarse count at the tap-sample cycle
//   out_fine          fine code 0..NTAPS-2
//   ovf, drop_cnt     sticky overflow flag and saturating dropped-event count
//   ovf_clr           clears ovf and drop_cnt
module tdc_fine_encoder #(
    parameter int NTAPS      = 101,
    parameter int FINE_W     = 7,
    parameter int COARSE_W   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NTAPS-1:0]    taps,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_pol,
    output logic [COARSE_W-1:0] out_coarse,
    output logic [FINE_W-1:0]   out_fine,
    output logic                ovf,
    input  logic                ovf_clr,
    output logic [7:0]          drop_cnt
);

    // Match count spans 1..NTAPS, which can need one bit more than the code.
    localparam int CNT_W = $clog2(NTAPS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic                pol;
        logic [COARSE_W-1:0] coarse;
        logic [FINE_W-1:0]   fine;
    } ts_t;

    // Free-running coarse counter
    logic [COARSE_W-1:0] coarse_q, coarse_d;

    // Two-flop re-sampling of the taps with the coarse value tagged along
    logic [NTAPS-1:0]    s1_q, s1_d;
    logic [NTAPS-1:0]    s2_q, s2_d;
    logic [COARSE_W-1:0] c1_q, c1_d;
    logic [COARSE_W-1:0] c2_q, c2_d;

    // Encoded stage
    logic                pol3_q, pol3_d;
    logic [FINE_W-1:0]   fine3_q, fine3_d;
    logic                edge3_q, edge3_d;
    logic [COARSE_W-1:0] c3_q, c3_d;

    // Edge-entry detection
    logic                edge_prev_q, edge_prev_d;

    // Timestamp queue
    ts_t                 mem_q [FIFO_DEPTH];
    ts_t                 mem_d [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
    ts_t                 hold_q, hold_d;

    // Overflow bookkeeping
    logic                ovf_q, ovf_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;

    // Combinational helpers
    logic [NTAPS-1:0]    match;
    logic [CNT_W-1:0]    match_cnt;
    logic                fifo_empty;
    logic                fifo_full;
    logic                ev;
    logic                pop;
    logic                push;
    logic                drop;
    logic [7:0]          drop_base;
    ts_t                 head;
    ts_t                 new_ts;
    ts_t                 out_ts;

    // ---------------------------------------------------------------
    // Coarse counter and sampling stages
    // ---------------------------------------------------------------
    always_comb begin
        coarse_d = coarse_q + COARSE_W'(1);
        s1_d     = taps;
        c1_d     = coarse_q;
        s2_d     = s1_q;
        c2_d     = c1_q;
    end

    // ---------------------------------------------------------------
    // Fine encoding. Counting the taps that agree with tap 0 is
    // insensitive to where a bubble sits, unlike a first-transition
    // search. A count of NTAPS means the line is uniform: no edge.
    // ---------------------------------------------------------------
    always_comb begin
        match     = ~(s2_q ^ {NTAPS{s2_q[0]}});
        match_cnt = '0;
        for (int i = 0; i < NTAPS; i++) begin
            match_cnt = match_cnt + CNT_W'(match[i]);
        end
        pol3_d  = s2_q[0];
        fine3_d = FINE_W'(match_cnt - CNT_W'(1));
        edge3_d = (match_cnt != CNT_W'(NTAPS));
        c3_d    = c2_q;
    end

    // ---------------------------------------------------------------
    // Event detection: only the first cycle of a run of edge samples
    // produces a timestamp.
    // ---------------------------------------------------------------
    always_comb begin
        ev          = edge3_q & ~edge_prev_q;
        edge_prev_d = edge3_q;
        new_ts      = '{pol: pol3_q, coarse: c3_q, fine: fine3_q};
    end

    // ---------------------------------------------------------------
    // FWFT queue. Pointers carry one wrap bit to tell full from empty.
    // A pop in the same cycle frees a slot, so a full queue still
    // accepts an event while the head is being consumed.
    // ---------------------------------------------------------------
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        head       = mem_q[rd_ptr_q[PTR_W-1:0]];
        pop        = ~fifo_empty & out_ready;
        push       = ev & (~fifo_full | pop);
        drop       = ev & fifo_full & ~pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        hold_d   = hold_q;

        if (push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = new_ts;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
            hold_d   = head;
        end
    end

    // ---------------------------------------------------------------
    // Overflow flag and drop counter. A drop in the clear cycle is
    // counted against the freshly cleared value.
    // ---------------------------------------------------------------
    always_comb begin
        drop_base  = ovf_clr ? 8'd0 : drop_cnt_q;
        ovf_d      = ovf_clr ? 1'b0 : ovf_q;
        drop_cnt_d = drop_base;
        if (drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = (drop_base == 8'hFF) ? 8'hFF : drop_base + 8'd1;
        end
    end

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            coarse_q    <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            pol3_q      <= 1'b0;
            fine3_q     <= '0;
            edge3_q     <= 1'b0;
            c3_q        <= '0;
            edge_prev_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            hold_q      <= '0;
            ovf_q       <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            coarse_q    <= coarse_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            pol3_q      <= pol3_d;
            fine3_q     <= fine3_d;
            edge3_q     <= edge3_d;
            c3_q        <= c3_d;
            edge_prev_q <= edge_prev_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            hold_q      <= hold_d;
            ovf_q       <= ovf_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs: an empty queue keeps showing the last consumed entry.
    // ---------------------------------------------------------------
    always_comb begin
        out_ts     = fifo_empty ? hold_q : head;
        out_valid  = ~fifo_empty;
        out_pol    = out_ts.pol;
        out_coarse = out_ts.coarse;
        out_fine   = out_ts.fine;
        ovf        = ovf_q;
        drop_cnt   = drop_cnt_q;
    end

endmodule
